// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // An access is rejected when it is not word aligned or when its word
    // index falls beyond the last word of the array.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: synchronous write, combinational read, never cleared.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Contents survive reset on purpose; only an explicit store changes them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for MEM-stage loads and stores. One access is held
// for LAT wait cycles, then answered with a single-cycle response strobe.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [31:0]       i_req_addr,
    input  logic [WORD_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    output logic [WORD_W-1:0] o_resp_rdata,
    output logic              o_resp_err,
    output logic              o_stall
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_write;
    logic              r_err;
    logic [AW-1:0]     r_index;
    logic [WORD_W-1:0] r_wdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [WORD_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic              w_last;
    logic              w_we;
    logic [WORD_W-1:0] w_rdata;

    // The last WAIT cycle is the single edge where the array is read and,
    // for a good store, written. Errored stores never touch the array.
    assign w_last = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_we   = w_last && r_write && !r_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (r_index),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // Request FSM: capture in IDLE, count down in WAIT, strobe in RESP.
    // Reset drops any pending access so a half-done store never commits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_index      <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_write     <= i_req_write;
                        r_err       <= addr_err(i_req_addr, DEPTH);
                        r_index     <= i_req_addr[AW+1:2];
                        r_wdata     <= i_req_wdata;
                        r_cnt       <= CNT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= r_err;
                        r_resp_rdata <= (r_write || r_err) ? '0 : w_rdata;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    // Stall also covers the acceptance cycle so the pipeline freezes at once.
    assign o_stall      = (r_state != IDLE) || ((r_state == IDLE) && i_req_valid);
    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table with a response
// scoreboard, plus hand sequences for back-to-back, reset and LAT=1 cases.
module tb_data_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LAT     = 2;
    localparam int TIMEOUT = 50;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expRdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid, reqWrite;
    logic [31:0] reqAddr, reqWdata;
    logic        reqReady, respValid, respErr, stall;
    logic [31:0] respRdata;

    logic        reqValid1, reqWrite1;
    logic [31:0] reqAddr1, reqWdata1;
    logic        reqReady1, respValid1, respErr1, stall1;
    logic [31:0] respRdata1;

    exp_t sbQ[$];
    int   respTimes[$];
    exp_t monE;
    int   cyc         = 0;
    int   nVec        = 0;
    int   nMis        = 0;
    int   respCount   = 0;
    int   lastRespCyc = -1;
    logic prevResp    = 1'b0;
    vec_t vecs[15];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_write  (reqWrite),
        .i_req_addr   (reqAddr),
        .i_req_wdata  (reqWdata),
        .o_resp_valid (respValid),
        .o_resp_rdata (respRdata),
        .o_resp_err   (respErr),
        .o_stall      (stall)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LAT(1)) dut1 (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_req_valid  (reqValid1),
        .o_req_ready  (reqReady1),
        .i_req_write  (reqWrite1),
        .i_req_addr   (reqAddr1),
        .i_req_wdata  (reqWdata1),
        .o_resp_valid (respValid1),
        .o_resp_rdata (respRdata1),
        .o_resp_err   (respErr1),
        .o_stall      (stall1)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every response strobe pops one expectation, and
    // two strobes in a row are flagged.
    always @(negedge clk) begin
        if (rstN && respValid) begin
            respCount++;
            lastRespCyc = cyc;
            respTimes.push_back(cyc);
            if (sbQ.size() == 0) begin
                nVec++;
                nMis++;
                $display("[TB] FAIL unexpected_resp: resp_valid=1 at cycle %0d with no pending request, required 0", cyc);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("resp_err", {31'b0, respErr}, {31'b0, monE.err});
                checkOutput("resp_rdata", respRdata, monE.rdata);
            end
            if (prevResp) checkOutput("resp_not_consecutive", {31'b0, respValid}, 32'd0);
        end
        prevResp = respValid;
    end

    function automatic vec_t mkVec(input logic w, input logic [31:0] a, input logic [31:0] d,
                                   input logic e, input logic [31:0] r);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.expErr = e; v.expRdata = r;
        return v;
    endfunction

    // Drive one access, then check handshake timing and the response latency.
    task automatic applyStimulus(input vec_t v);
        int guard, lowCnt, stallLow, acceptCyc, cntBefore;
        guard = 0;
        @(negedge clk);
        while (!reqReady && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_before_req", {31'b0, reqReady}, 32'd1);
        checkOutput("stall_idle", {31'b0, stall}, 32'd0);
        cntBefore = respCount;
        reqValid  = 1'b1;
        reqWrite  = v.write;
        reqAddr   = v.addr;
        reqWdata  = v.wdata;
        sbQ.push_back('{err: v.expErr, rdata: v.expRdata});
        #1;
        checkOutput("stall_on_valid", {31'b0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        acceptCyc = cyc;
        reqValid  = 1'b0;
        lowCnt    = 0;
        stallLow  = 0;
        while (!reqReady && lowCnt < TIMEOUT) begin
            lowCnt++;
            if (!stall) stallLow++;
            @(negedge clk);
        end
        checkOutput("ready_low_cycles", lowCnt, LAT + 1);
        checkOutput("stall_while_busy", stallLow, 0);
        checkOutput("resp_count", respCount, cntBefore + 1);
        checkOutput("resp_latency", lastRespCyc - acceptCyc, LAT);
    endtask

    initial begin
        #200000;
        nMis++;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, n, got, m, cntSnap;
        int t1[2];
        logic [31:0] d1[2];

        vecs[0]  = mkVec(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        vecs[1]  = mkVec(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
        vecs[2]  = mkVec(1'b1, 32'h0000_0013, 32'h0000_0BAD, 1'b1, 32'h0);
        vecs[3]  = mkVec(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
        vecs[4]  = mkVec(1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0);
        vecs[5]  = mkVec(1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0);
        vecs[6]  = mkVec(1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D);
        vecs[7]  = mkVec(1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h0);
        vecs[8]  = mkVec(1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0000);
        vecs[9]  = mkVec(1'b0, 32'h0000_03FE, 32'h0,         1'b1, 32'h0);
        vecs[10] = mkVec(1'b1, 32'h0000_0410, 32'h1111_1111, 1'b1, 32'h0);
        vecs[11] = mkVec(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
        vecs[12] = mkVec(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 32'h0);
        vecs[13] = mkVec(1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0BAD_F00D);
        vecs[14] = mkVec(1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0);

        rstN = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
        reqValid1 = 1'b0; reqWrite1 = 1'b0; reqAddr1 = '0; reqWdata1 = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, reqReady}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, respValid}, 32'd0);
        checkOutput("rst_resp_rdata", respRdata, 32'd0);
        checkOutput("rst_resp_err", {31'b0, respErr}, 32'd0);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        rstN = 1'b1;

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

        // Back-to-back: valid held high over four loads.
        @(negedge clk);
        base     = respTimes.size();
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h10;
        for (int i = 0; i < 4; i++) sbQ.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (respValid) begin
                n++;
                if (n == 4) reqValid = 1'b0;
            end
        end
        reqValid = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("b2b_count", respTimes.size() - base, 4);
        checkOutput("b2b_queue_empty", sbQ.size(), 0);
        if (respTimes.size() >= base + 4) begin
            for (int i = 1; i < 4; i++)
                checkOutput("b2b_spacing", respTimes[base+i] - respTimes[base+i-1], LAT + 2);
        end

        // Reset while a store of 0x12345678 to 0x20 is in WAIT.
        @(negedge clk);
        cntSnap  = respCount;
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h20; reqWdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        checkOutput("midwait_ready_low", {31'b0, reqReady}, 32'd0);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midrst_req_ready", {31'b0, reqReady}, 32'd1);
        checkOutput("midrst_resp_valid", {31'b0, respValid}, 32'd0);
        checkOutput("midrst_resp_rdata", respRdata, 32'd0);
        checkOutput("midrst_resp_err", {31'b0, respErr}, 32'd0);
        checkOutput("midrst_stall", {31'b0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("no_resp_after_reset", respCount, cntSnap);
        applyStimulus(mkVec(1'b0, 32'h20, 32'h0, 1'b0, 32'h0000_0000));

        // Request held through reset release is taken on the first edge.
        @(negedge clk);
        rstN = 1'b0;
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h10;
        cntSnap = respCount;
        sbQ.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        @(negedge clk);
        rstN = 1'b1;
        m = cyc;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        for (int i = 0; i < TIMEOUT && respCount == cntSnap; i++) @(negedge clk);
        checkOutput("rst_release_resp_count", respCount, cntSnap + 1);
        checkOutput("rst_release_latency", lastRespCyc - (m + 1), LAT);

        // LAT=1 instance: store then held load, checking turnaround.
        @(negedge clk);
        reqValid1 = 1'b1; reqWrite1 = 1'b1; reqAddr1 = 32'h8; reqWdata1 = 32'hA5A5_5A5A;
        @(posedge clk);
        @(negedge clk);
        m = cyc;
        reqWrite1 = 1'b0;
        checkOutput("lat1_ready_low", {31'b0, reqReady1}, 32'd0);
        got = 0;
        t1[0] = -1; t1[1] = -1; d1[0] = 'x; d1[1] = 'x;
        for (int i = 0; i < 15 && got < 2; i++) begin
            if (respValid1) begin
                t1[got] = cyc;
                d1[got] = respRdata1;
                got++;
                if (got == 2) reqValid1 = 1'b0;
            end
            if (got < 2) @(negedge clk);
        end
        reqValid1 = 1'b0;
        checkOutput("lat1_resp_count", got, 2);
        checkOutput("lat1_first_latency", t1[0] - m, 1);
        checkOutput("lat1_second_latency", t1[1] - m, 4);
        checkOutput("lat1_store_rdata", d1[0], 32'h0);
        checkOutput("lat1_load_rdata", d1[1], 32'hA5A5_5A5A);

        repeat (4) @(negedge clk);
        checkOutput("final_queue_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
